// File: rtl/cla_seq_wide_adder.sv
// cla_seq_wide_adder
//   Wide adder built from one shared 4-bit carry-look-ahead slice, stepped
//   one nibble per cycle from the least-significant end. The carry between
//   nibbles is held in a register.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for operands; in_ready high
//   RUN   | one nibble per cycle through the CLA slice
//   DONE  | result held; out_valid high until out_ready
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (a, b, cin)
//   out_valid/out_ready result handshake (sum, cout, ovf)
//   busy                high while in RUN or DONE
module cla_seq_wide_adder #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         busy
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_next;
  logic [W-1:0]   op_a, op_b, sum_r;
  logic           carry, cout_r, ovf_r;
  logic [IW-1:0]  idx;

  logic [IW+1:0]  sh;
  logic [3:0]     na, nb, p, g, s;
  logic           c0, c1, c2, c3, c4;
  logic           last;
  logic [W-1:0]   sum_next;

  // CLA slice on the current nibble; bit offset of the nibble is idx*4.
  always_comb begin
    sh = {idx, 2'b00};
    na = 4'(op_a >> sh);
    nb = 4'(op_b >> sh);
    p  = na ^ nb;
    g  = na & nb;
    c0 = carry;
    c1 = g[0] | (p[0] & c0);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & c0);
    s  = p ^ {c3, c2, c1, c0};
    last = (idx == IW'(NIBBLES - 1));
    // Merge the slice result into its nibble of the running sum.
    sum_next = (sum_r & ~(W'(4'hF) << sh)) | (W'(s) << sh);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a   <= a;
            op_b   <= b;
            carry  <= cin;
            idx    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
          end
        end
        RUN: begin
          sum_r <= sum_next;
          carry <= c4;
          if (last) begin
            idx    <= '0;
            cout_r <= c4;
            // carry into MSB xor carry out of MSB
            ovf_r  <= c3 ^ c4;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_cla_seq_wide_adder.sv
module tb_cla_seq_wide_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        iv4, ir4, ov4, or4, cin4, co4, ovf4, busy4;
  logic [15:0] a4, b4, s4;
  // 4-bit instance
  logic        iv1, ir1, ov1, or1, cin1, co1, ovf1, busy1;
  logic [3:0]  a1, b1, s1;

  cla_seq_wide_adder #(.NIBBLES(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .cin(cin4),
    .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4), .ovf(ovf4), .busy(busy4));

  cla_seq_wide_adder #(.NIBBLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(cin1),
    .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1), .ovf(ovf1), .busy(busy1));

  int checks = 0;
  int errors = 0;
  logic [17:0] q4[$];
  logic [17:0] q1[$];
  int acc4 = 0, res4 = 0, acc1 = 0, res1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer addition, packed as {cout, ovf, sum}.
  function automatic logic [17:0] model(input int w, input logic [15:0] x,
                                        input logic [15:0] y, input logic c);
    logic [31:0] full;
    logic [15:0] mask, sm;
    logic        co, ov;
    full = {16'b0, x} + {16'b0, y} + {31'b0, c};
    mask = 16'hFFFF >> (16 - w);
    sm   = full[15:0] & mask;
    co   = full[w];
    ov   = (x[w-1] == y[w-1]) && (sm[w-1] != x[w-1]);
    return {co, ov, sm};
  endfunction

  // Scoreboard: push on accepted input, pop and compare on accepted output.
  always @(negedge clk) begin
    if (rst_n) begin
      if (iv4 && ir4) begin
        q4.push_back(model(16, a4, b4, cin4));
        acc4++;
      end
      if (ov4 && or4) begin
        if (q4.size() == 0) chk("u4_unexpected_result", 1, 0);
        else chk("u4_result", {14'b0, co4, ovf4, s4}, {14'b0, q4.pop_front()});
        res4++;
      end
      if (iv1 && ir1) begin
        q1.push_back(model(4, {12'b0, a1}, {12'b0, b1}, cin1));
        acc1++;
      end
      if (ov1 && or1) begin
        if (q1.size() == 0) chk("u1_unexpected_result", 1, 0);
        else chk("u1_result", {14'b0, co1, ovf1, 12'b0, s1}, {14'b0, q1.pop_front()});
        res1++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                       input logic [15:0] es, input logic eco, input logic eovf,
                       input int hold, input bit disturb);
    int n;
    chk("idle_in_ready", ir4, 1);
    iv4 = 1'b1; a4 = xa; b4 = xb; cin4 = xc;
    tick();
    iv4 = 1'b0;
    n = 0;
    while (!ov4 && n < 20) begin
      if (disturb) begin
        a4 = 16'($urandom); b4 = 16'($urandom); iv4 = 1'($urandom); cin4 = 1'($urandom);
      end
      tick();
      n++;
    end
    iv4 = 1'b0;
    chk("latency", n, 4);
    chk("sum", s4, es);
    chk("cout", co4, eco);
    chk("ovf", ovf4, eovf);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_state", {ov4, ir4, busy4}, 3'b101);
      chk("hold_outputs", {co4, ovf4, s4}, {eco, eovf, es});
    end
    or4 = 1'b1;
    tick();
    or4 = 1'b0;
  endtask

  task automatic rand4();
    int tgt_acc, tgt_res, cyc;
    tgt_acc = acc4 + 1000;
    tgt_res = res4 + 1000;
    cyc = 0;
    while ((acc4 < tgt_acc || res4 < tgt_res) && cyc < 40000) begin
      tick();
      iv4  = (acc4 < tgt_acc) ? 1'($urandom_range(0, 1)) : 1'b0;
      a4   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      b4   = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      cin4 = 1'($urandom);
      or4  = 1'($urandom_range(0, 1));
      cyc++;
    end
    iv4 = 1'b0; or4 = 1'b0;
    chk("rand4_accepts", acc4, tgt_acc);
    chk("rand4_results", res4, tgt_res);
    chk("rand4_queue_empty", q4.size(), 0);
  endtask

  task automatic rand1();
    int tgt_acc, tgt_res, cyc;
    tgt_acc = acc1 + 1000;
    tgt_res = res1 + 1000;
    cyc = 0;
    while ((acc1 < tgt_acc || res1 < tgt_res) && cyc < 40000) begin
      tick();
      iv1  = (acc1 < tgt_acc) ? 1'($urandom_range(0, 1)) : 1'b0;
      a1   = 4'($urandom);
      b1   = 4'($urandom);
      cin1 = 1'($urandom);
      or1  = 1'($urandom_range(0, 1));
      cyc++;
    end
    iv1 = 1'b0; or1 = 1'b0;
    chk("rand1_accepts", acc1, tgt_acc);
    chk("rand1_results", res1, tgt_res);
    chk("rand1_queue_empty", q1.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    iv4 = 0; or4 = 0; a4 = 0; b4 = 0; cin4 = 0;
    iv1 = 0; or1 = 0; a1 = 0; b1 = 0; cin1 = 0;
    #2;
    chk("reset_u4", {ir4, ov4, busy4, co4, ovf4, s4}, {5'b10000, 16'h0000});
    chk("reset_u1", {ir1, ov1, busy1, co1, ovf1, s1}, {5'b10000, 4'h0});
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0, 1'b0);
    do_op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
    do_op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 0, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 10, 1'b0);
    do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
    do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0, 1'b1);

    // Reset while the third nibble is in the slice (two nibbles already written).
    iv4 = 1'b1; a4 = 16'hFFFF; b4 = 16'hFFFF; cin4 = 1'b1;
    tick();
    iv4 = 1'b0;
    tick();
    tick();
    chk("mid_run_busy", {busy4, ov4}, 2'b10);
    rst_n = 1'b0;
    q4.delete();
    q1.delete();
    #1;
    chk("async_reset_outputs", {ir4, ov4, busy4, co4, ovf4, s4}, {5'b10000, 16'h0000});
    #2;
    rst_n = 1'b1;
    tick();
    do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0, 1'b0);

    fork
      rand4();
      rand1();
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
